// File: rtl/instr_streamer_pkg.sv
// -----------------------------------------------------------------------------
// instr_streamer_pkg
// Shared definitions for the instruction streamer slice.
//   state_t   : streamer FSM state encoding (IDLE / STREAM / FLUSH)
//   OP_*      : 7-bit opcode constants used by the decoder
// -----------------------------------------------------------------------------
package instr_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/instr_streamer_decoder.sv
// -----------------------------------------------------------------------------
// instr_decoder
// Combinational opcode decoder: maps an instruction word to the RegWrite and
// ALUSrc control bits consumed downstream.
// Ports:
//   instr     in  [Instruction_word_size-1:0]  word being issued
//   reg_write out                               register write enable
//   alu_src   out                               immediate operand select
// -----------------------------------------------------------------------------
module instr_decoder
    import instr_streamer_pkg::*;
#(
    parameter int Instruction_word_size = 32
) (
    input  logic [Instruction_word_size-1:0] instr,
    output logic                             reg_write,
    output logic                             alu_src
);

    logic [6:0] opcode;
    logic       unused_hi;

    assign opcode    = instr[6:0];
    // Only the opcode field matters for these two controls.
    assign unused_hi = ^instr[Instruction_word_size-1:7];

    always_comb begin
        reg_write = 1'b0;
        alu_src   = 1'b0;
        case (opcode)
            OP_R: begin
                reg_write = 1'b1;
            end
            OP_I, OP_LOAD: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
            end
            OP_STORE: begin
                alu_src   = 1'b1;
            end
            // OP_BRANCH, the all-zero flush word and anything unknown
            // leave both controls low.
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_streamer.sv
// -----------------------------------------------------------------------------
// instr_streamer
// Small program store that is loaded word by word in IDLE, then streamed out
// one word per cycle on start, followed by flush_len all-zero terminator words.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   load_en    in   append load_data to the store (IDLE only, dropped when full)
//   load_data  in   word to append
//   clear      in   empty the store (IDLE only, wins over load_en)
//   start      in   stream the stored program (IDLE only, needs a word to send)
//   Instr_out  out  registered streamed word, zero outside STREAM
//   RegWrite   out  registered decode of Instr_out
//   ALUSrc     out  registered decode of Instr_out
//   busy       out  high in STREAM and FLUSH
//   done       out  one-cycle pulse on the return to IDLE
//   full       out  store holds depth words
//   count      out  number of stored words
//   state_dbg  out  current FSM state (state_t encoding)
//
// Handshake: inputs are plain level-sampled commands, acted on at the rising
// edge they are seen high; there is no back-pressure from the consumer, so a
// word on Instr_out is valid for exactly the one cycle it is presented.
// -----------------------------------------------------------------------------
module instr_streamer
    import instr_streamer_pkg::*;
#(
    parameter int Instruction_word_size = 32,
    parameter int depth                 = 16,
    parameter int flush_len             = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             load_en,
    input  logic [Instruction_word_size-1:0] load_data,
    input  logic                             clear,
    input  logic                             start,
    output logic [Instruction_word_size-1:0] Instr_out,
    output logic                             RegWrite,
    output logic                             ALUSrc,
    output logic                             busy,
    output logic                             done,
    output logic                             full,
    output logic [$clog2(depth):0]           count,
    output logic [1:0]                       state_dbg
);

    localparam int AW = (depth > 1) ? $clog2(depth) : 1;
    localparam int CW = $clog2(depth) + 1;
    localparam int FW = (flush_len > 1) ? $clog2(flush_len) : 1;

    localparam logic [CW-1:0] DEPTH_C    = CW'(depth);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(flush_len - 1);

    state_t                           state;
    logic [CW-1:0]                    rd_ptr;
    logic [FW-1:0]                    flush_cnt;
    logic [Instruction_word_size-1:0] mem [depth];

    logic                             load_fire;
    logic                             start_fire;
    logic [Instruction_word_size-1:0] issue_word;
    logic                             dec_rw;
    logic                             dec_as;

    assign full      = (count == DEPTH_C);
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

    assign load_fire  = (state == ST_IDLE) && load_en && !clear && !full;
    // A start that coincides with a clear is dropped with the program it
    // would have streamed. A start on an empty store still fires when a
    // word is being loaded in the same cycle.
    assign start_fire = (state == ST_IDLE) && start && !clear &&
                        ((count != '0) || load_fire);

    // Word presented on the next cycle. On start with an empty store the
    // first word is the one being written this same cycle, so bypass it.
    always_comb begin
        issue_word = '0;
        if (start_fire) begin
            issue_word = (count == '0) ? load_data : mem[0];
        end else if ((state == ST_STREAM) && (rd_ptr != count)) begin
            issue_word = mem[rd_ptr[AW-1:0]];
        end
    end

    instr_decoder #(
        .Instruction_word_size(Instruction_word_size)
    ) u_decoder (
        .instr     (issue_word),
        .reg_write (dec_rw),
        .alu_src   (dec_as)
    );

    // Store contents are not reset; count==0 marks them invalid.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            mem[count[AW-1:0]] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            rd_ptr    <= '0;
            flush_cnt <= '0;
            Instr_out <= '0;
            RegWrite  <= 1'b0;
            ALUSrc    <= 1'b0;
            done      <= 1'b0;
        end else begin
            Instr_out <= issue_word;
            RegWrite  <= dec_rw;
            ALUSrc    <= dec_as;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clear) begin
                        count <= '0;
                    end else if (load_fire) begin
                        count <= count + 1'b1;
                    end
                    if (start_fire) begin
                        state  <= ST_STREAM;
                        rd_ptr <= CW'(1);
                    end
                end
                ST_STREAM: begin
                    // rd_ptr==count means slot count-1 is on the output now.
                    if (rd_ptr == count) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= '0;
                    end else begin
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) begin
                        state  <= ST_IDLE;
                        rd_ptr <= '0;
                        done   <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_streamer.sv
// -----------------------------------------------------------------------------
// tb_instr_streamer
// Randomised bench for instr_streamer. The reference model is a queue holding
// the stored program; a stream is expected to be exactly that queue followed
// by FLUSH zero words, each decoded from the opcode table.
// -----------------------------------------------------------------------------
module tb_instr_streamer;

    localparam int W     = 32;
    localparam int DEPTH = 16;
    localparam int FLUSH = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         load_en;
    logic [W-1:0] load_data;
    logic         clear;
    logic         start;
    logic [W-1:0] Instr_out;
    logic         RegWrite;
    logic         ALUSrc;
    logic         busy;
    logic         done;
    logic         full;
    logic [4:0]   count;
    logic [1:0]   state_dbg;

    instr_streamer #(
        .Instruction_word_size(W),
        .depth                (DEPTH),
        .flush_len            (FLUSH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .load_data (load_data),
        .clear     (clear),
        .start     (start),
        .Instr_out (Instr_out),
        .RegWrite  (RegWrite),
        .ALUSrc    (ALUSrc),
        .busy      (busy),
        .done      (done),
        .full      (full),
        .count     (count),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] prog_q[$];
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {RegWrite, ALUSrc} from the opcode table.
    function automatic logic [1:0] ref_dec(input logic [W-1:0] w);
        case (w[6:0])
            7'b0110011:             return 2'b10;
            7'b0010011, 7'b0000011: return 2'b11;
            7'b0100011:             return 2'b01;
            default:                return 2'b00;
        endcase
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        w = $urandom;
        case ($urandom_range(0, 5))
            0: w[6:0] = 7'b0110011;
            1: w[6:0] = 7'b0010011;
            2: w[6:0] = 7'b0000011;
            3: w[6:0] = 7'b0100011;
            4: w[6:0] = 7'b1100011;
            default: ;
        endcase
        return w;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b0; load_en = 1'b0; clear = 1'b0; start = 1'b0; load_data = '0;
        #1;
        check("rst_count", count, 0);
        check("rst_instr", Instr_out, 0);
        check("rst_regwrite", RegWrite, 0);
        check("rst_alusrc", ALUSrc, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_full", full, 0);
        check("rst_state", state_dbg, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        prog_q.delete();
    endtask

    task automatic load_word(input logic [W-1:0] w);
        load_en = 1'b1; load_data = w;
        @(posedge clk); #1;
        load_en = 1'b0;
        if (prog_q.size() < DEPTH) prog_q.push_back(w);
        check("load_count", count, prog_q.size());
        check("load_full", full, prog_q.size() == DEPTH);
    endtask

    task automatic do_clear(input bit with_load);
        clear = 1'b1; load_en = with_load; load_data = $urandom;
        @(posedge clk); #1;
        clear = 1'b0; load_en = 1'b0;
        prog_q.delete();
        check("clear_count", count, 0);
        check("clear_full", full, 0);
    endtask

    task automatic start_ignored();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (FLUSH + 4) begin
            check("ign_busy", busy, 0);
            check("ign_instr", Instr_out, 0);
            check("ign_done", done, 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic run_stream(input bit with_load, input logic [W-1:0] w, input bit noise);
        logic [W-1:0] e;
        logic [1:0]   d;
        start = 1'b1; load_en = with_load; load_data = w;
        @(posedge clk); #1;
        start = 1'b0; load_en = 1'b0;
        if (with_load && prog_q.size() < DEPTH) prog_q.push_back(w);
        exp_q.delete();
        foreach (prog_q[i]) exp_q.push_back(prog_q[i]);
        repeat (FLUSH) exp_q.push_back('0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            d = ref_dec(e);
            check("str_instr", Instr_out, e);
            check("str_regwrite", RegWrite, d[1]);
            check("str_alusrc", ALUSrc, d[0]);
            check("str_busy", busy, 1);
            check("str_done", done, 0);
            if (noise) begin
                load_en   = 1'($urandom_range(0, 1));
                clear     = 1'($urandom_range(0, 1));
                start     = 1'($urandom_range(0, 1));
                load_data = $urandom;
            end
            @(posedge clk); #1;
        end
        load_en = 1'b0; clear = 1'b0; start = 1'b0;
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_instr", Instr_out, 0);
        check("end_count", count, prog_q.size());
        @(posedge clk); #1;
        check("post_done", done, 0);
        check("post_busy", busy, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] w0, w1;
        int n;

        do_reset();

        // Start on an empty store does nothing.
        start_ignored();

        // Directed three-word program.
        load_word(32'h00208033);
        load_word(32'h00500093);
        load_word(32'h0020A023);
        run_stream(1'b0, '0, 1'b0);

        // Replay with ignored commands thrown at the busy streamer.
        run_stream(1'b0, '0, 1'b1);

        // Clear beats a simultaneous load.
        do_clear(1'b1);

        // Overfill: the 17th load is dropped.
        for (int i = 0; i < DEPTH + 1; i++) load_word(rand_word());
        check("ovf_count", count, DEPTH);
        run_stream(1'b0, '0, 1'b0);

        // Load together with start, first on an empty store, then on a short one.
        do_clear(1'b0);
        run_stream(1'b1, rand_word(), 1'b0);
        load_word(rand_word());
        run_stream(1'b1, rand_word(), 1'b0);

        // Reset on the second streamed word.
        do_clear(1'b0);
        w0 = rand_word();
        w1 = rand_word();
        load_word(w0);
        load_word(w1);
        load_word(rand_word());
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("mid_w0", Instr_out, w0);
        @(posedge clk); #1;
        check("mid_w1", Instr_out, w1);
        rst = 1'b0;
        #1;
        check("mid_rst_instr", Instr_out, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_regwrite", RegWrite, 0);
        check("mid_rst_alusrc", ALUSrc, 0);
        prog_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        start_ignored();

        // Random programs.
        for (int r = 0; r < 8; r++) begin
            do_clear(1'b0);
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) load_word(rand_word());
            run_stream(1'($urandom_range(0, 1)), rand_word(), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_streamer.md
INSTR_STREAMER -- requirements
Module: instr_streamer

Interface
REQ-001 Parameter Instruction_word_size, default 32, width of every instruction word.
REQ-002 Parameter depth, default 16, number of instruction slots in the program store.
REQ-003 Parameter flush_len, default 16, number of all-zero terminator words emitted after the program.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 load_en  input  1  write load_data into the next free store slot.
REQ-007 load_data  input  Instruction_word_size  instruction word to be stored.
REQ-008 clear  input  1  empty the program store.
REQ-009 start  input  1  begin streaming the stored program.
REQ-010 Instr_out  output  Instruction_word_size  streamed instruction word to the ESM consumer.
REQ-011 RegWrite  output  1  decoded write-enable for the word on Instr_out.
REQ-012 ALUSrc  output  1  decoded immediate-select for the word on Instr_out.
REQ-013 busy  output  1  high in STREAM and FLUSH.
REQ-014 done  output  1  one-cycle pulse when the flush completes.
REQ-015 full  output  1  store holds depth words.
REQ-016 count  output  $clog2(depth)+1  number of stored words.

Function
REQ-017 FSM states: IDLE, STREAM, FLUSH.
- IDLE -> STREAM on start with count>0.
- STREAM -> FLUSH after the word at index count-1 is issued.
- FLUSH -> IDLE after flush_len zero words.
REQ-018 In IDLE, start with count==0 is ignored, and start in STREAM or FLUSH is ignored.
REQ-019 In IDLE, load_en writes load_data to slot count and increments count when full==0; load_en with full==1 is dropped and leaves the store unchanged.
REQ-020 load_en and clear are ignored outside IDLE; in IDLE, clear sets count to 0 and takes priority over a simultaneous load_en.
REQ-021 Simultaneous load_en and start in IDLE: the load is performed, and streaming includes the newly loaded word.
REQ-022 Instr_out, RegWrite and ALUSrc are registered.
- The first program word appears on the cycle after start is sampled.
- One word is issued per cycle with no gaps.
REQ-023 Instr_out is all-zero in IDLE and in FLUSH; RegWrite=ALUSrc=0 whenever Instr_out is zero.
REQ-024 Decode uses opcode bits [6:0] of the word being issued:
- 0110011: RegWrite=1, ALUSrc=0.
- 0010011 or 0000011: RegWrite=1, ALUSrc=1.
- 0100011: RegWrite=0, ALUSrc=1.
- 1100011 and all other opcodes: RegWrite=0, ALUSrc=0.
REQ-025 done asserts for exactly one cycle, on the cycle the FSM returns to IDLE; busy is low on that cycle.
REQ-026 The read pointer wraps to 0 only via the FLUSH->IDLE transition.
REQ-027 The store contents and count are preserved across a stream, so a second start replays the same program.
REQ-028 The flush counter counts 0..flush_len-1.

Reset
REQ-029 While rst is low, regardless of clk:
- FSM is in IDLE; count, read pointer and flush counter are 0.
- Instr_out=0; RegWrite, ALUSrc, busy, done and full are 0.
REQ-030 Reset asserted mid-STREAM or mid-FLUSH aborts immediately, with all REQ-029 values on the next observable instant.
REQ-031 Store memory contents need no reset; count=0 invalidates them.

Structure
REQ-032 A shared package holds:
- the FSM state enumeration;
- the opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH.
REQ-033 One sub-module, instr_decoder, is combinational and maps an instruction word to RegWrite/ALUSrc; instr_streamer registers its outputs.

Verification
REQ-034 Reset, load 3 words (0x00208033, 0x00500093, 0x0020A023), start.
- Cycles 1-3 after start: Instr_out = those words, with RegWrite/ALUSrc = 1/0, 1/1, 0/1.
- Then 16 zero words, then done pulses once.
REQ-035 Load 17 words with depth=16 -> full=1 after the 16th load, count=16, 17th word dropped, stream issues exactly 16 words.
REQ-036 start with count==0 -> busy stays 0, Instr_out stays 0, no done pulse.
REQ-037 Pull rst low on the 2nd streamed word -> Instr_out=0, busy=0, count=0 immediately; a later start with no load is ignored.
REQ-038 clear and load_en asserted in the same IDLE cycle -> count=0.
REQ-039 Stream, wait for done, start again -> identical word sequence replayed; load_en during STREAM leaves count unchanged.
